// File: rtl/pre_ctrl_pkg.sv
// Shared definitions for the branch predictor maintenance/update sequencer.
package pre_ctrl_pkg;

  localparam int PRE_ADDR_LEN   = 32;
  localparam int PRE_INDEX_BITS = 7;
  localparam int PRE_TAG_BITS   = 8;
  localparam int PRE_FIFO_DEPTH = 4;

  // The predictor applies this pattern whenever upd_init is high:
  // the tag MSB is set (never matches a real lookup) and the history is weakly taken.
  localparam logic       PRE_INIT_TAG_MSB = 1'b1;
  localparam logic [1:0] PRE_INIT_HIST    = 2'b10;

  typedef enum logic {
    PRE_INIT = 1'b0,
    PRE_RUN  = 1'b1
  } pre_state_e;

endpackage

// File: rtl/pre_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates for the predictor write port.
module pre_upd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  // Advance pointers; a simultaneous push and pop on a full FIFO is legal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pre_ctrl.sv
// Predictor maintenance sequencer: init sweep after reset, then queued EX updates,
// plus a registered one-cycle mispredict flush/redirect towards IF.
import pre_ctrl_pkg::*;

module pre_ctrl #(
  parameter int ADDR_LEN   = PRE_ADDR_LEN,
  parameter int INDEX_BITS = PRE_INDEX_BITS,
  parameter int TAG_BITS   = PRE_TAG_BITS,
  parameter int FIFO_DEPTH = PRE_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  ex_jump,
  input  logic                  ex_jump_plus,
  input  logic [ADDR_LEN-1:0]   pc_ex,
  input  logic [ADDR_LEN-1:0]   ex_jump_target,
  input  logic                  ex_pred_jump,
  input  logic [ADDR_LEN-1:0]   ex_pred_target,
  output logic                  pre_busy,
  output logic                  upd_we,
  output logic                  upd_init,
  output logic [INDEX_BITS-1:0] upd_index,
  output logic [TAG_BITS-1:0]   upd_tag,
  output logic                  upd_taken,
  output logic [ADDR_LEN-1:0]   upd_target,
  output logic                  flush,
  output logic [ADDR_LEN-1:0]   redirect_pc,
  output logic [15:0]           drop_cnt
);

  localparam int ENTRY_W = INDEX_BITS + TAG_BITS + 1 + ADDR_LEN;
  localparam logic [INDEX_BITS-1:0] IDX_ONE  = {{(INDEX_BITS-1){1'b0}}, 1'b1};
  localparam logic [INDEX_BITS-1:0] IDX_LAST = '1;
  localparam logic [ADDR_LEN-1:0]   PC_STEP  = {{(ADDR_LEN-3){1'b0}}, 3'b100};
  localparam logic [15:0]           DROP_MAX = 16'hFFFF;
  localparam logic [15:0]           DROP_ONE = 16'd1;

  // Handshake: upd_we is the write valid; the predictor write port is always ready,
  // so every cycle with upd_we = 1 is one accepted write. rdy = 0 freezes the whole
  // block: no write, no push, no pop, and every register holds.

  pre_state_e            state;
  logic [INDEX_BITS-1:0] init_idx;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic                  full;
  logic                  empty;
  logic                  mis;
  logic [ENTRY_W-1:0]    push_entry;
  logic [ENTRY_W-1:0]    head;
  logic [INDEX_BITS-1:0] head_index;
  logic [TAG_BITS-1:0]   head_tag;
  logic                  head_taken;
  logic [ADDR_LEN-1:0]   head_target;

  assign push_entry = {pc_ex[INDEX_BITS+1:2],
                       pc_ex[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2],
                       ex_jump_plus, ex_jump_target};
  assign {head_index, head_tag, head_taken, head_target} = head;

  assign pop  = rdy && (state == PRE_RUN) && !empty;
  assign push = rdy && ex_jump && (!full || pop);
  assign drop = rdy && ex_jump && full && !pop;
  assign mis  = (ex_pred_jump != ex_jump_plus) ||
                (ex_jump_plus && (ex_pred_target != ex_jump_target));

  assign pre_busy = (state == PRE_INIT);

  pre_upd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // State machine and sweep counter: one index per ready cycle, then RUN forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PRE_INIT;
      init_idx <= '0;
    end else if (rdy && state == PRE_INIT) begin
      init_idx <= init_idx + IDX_ONE;
      if (init_idx == IDX_LAST) state <= PRE_RUN;
    end
  end

  // Write port: sweep pattern during INIT, FIFO head during RUN; silent under reset.
  always_comb begin
    upd_we     = 1'b0;
    upd_init   = 1'b0;
    upd_index  = '0;
    upd_tag    = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    if (!rst && rdy) begin
      if (state == PRE_INIT) begin
        upd_we    = 1'b1;
        upd_init  = 1'b1;
        upd_index = init_idx;
      end else if (!empty) begin
        upd_we     = 1'b1;
        upd_index  = head_index;
        upd_tag    = head_tag;
        upd_taken  = head_taken;
        upd_target = head_target;
      end
    end
  end

  // Mispredict flush is raised for every resolved branch, even one the FIFO drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else if (rdy) begin
      flush <= ex_jump && mis;
      if (ex_jump) redirect_pc <= ex_jump_plus ? ex_jump_target : pc_ex + PC_STEP;
    end
  end

  // Saturating count of events lost to a full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != DROP_MAX) begin
      drop_cnt <= drop_cnt + DROP_ONE;
    end
  end

endmodule
